// File: rtl/pc_sequencer.sv
// Architectural PC register and run-control FSM (boot, run, drain, halt/fault, watchdog).
// Latency: all outputs are registered; pc_o and status change one edge after the inputs that cause them.
// Backpressure: run_i=0 pauses sequencing with PC and counters frozen; exceptions are still taken.
module pc_sequencer #(
    parameter int                    DATA_WIDTH   = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = 64'h0000_0000_8000_0000,
    parameter int                    DRAIN_CYCLES = 3,
    parameter int                    WDT_WIDTH    = 16,
    parameter logic [WDT_WIDTH-1:0]  WDT_LIMIT    = 16'd1000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] new_pc_i,
    input  logic [3:0]            exceptions_i,
    input  logic                  run_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [2:0]            state_o,
    output logic                  halted_o,
    output logic                  fault_o,
    output logic [2:0]            cause_o,
    output logic [DATA_WIDTH-1:0] cycle_cnt_o
);

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_HALTED = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_NONE     = 3'd0,
        C_FETCH    = 3'd1,
        C_DECODE   = 3'd2,
        C_ECALL    = 3'd3,
        C_EBREAK   = 3'd4,
        C_WDOG     = 3'd5,
        C_MISALIGN = 3'd6
    } cause_t;

    localparam int                   DCW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0]       DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);
    localparam logic [WDT_WIDTH-1:0] WDT_LAST   = WDT_LIMIT - WDT_WIDTH'(1);

    state_t                  state_q, state_d;
    cause_t                  cause_q, cause_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   cyc_q, cyc_d;
    logic [WDT_WIDTH-1:0]    wdt_q, wdt_d;
    logic [DCW-1:0]          drain_q, drain_d;
    logic                    halted_q, fault_q;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        cyc_d   = cyc_q;
        wdt_d   = wdt_q;
        drain_d = drain_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (|exceptions_i[1:0]) begin
                    state_d = ST_FAULT;
                    cause_d = exceptions_i[0] ? C_FETCH : C_DECODE;
                end else if (|exceptions_i[3:2]) begin
                    state_d = ST_DRAIN;
                    cause_d = exceptions_i[2] ? C_ECALL : C_EBREAK;
                    drain_d = DRAIN_LOAD;
                end else if (!run_i) begin
                    state_d = ST_RUN;
                end else if (|new_pc_i[1:0]) begin
                    state_d = ST_FAULT;
                    cause_d = C_MISALIGN;
                end else begin
                    pc_d  = new_pc_i;
                    cyc_d = cyc_q + DATA_WIDTH'(1);
                    if (new_pc_i == pc_q) begin
                        wdt_d = wdt_q + WDT_WIDTH'(1);
                        // Fault on the increment that would make the stall count reach WDT_LIMIT.
                        if (wdt_q == WDT_LAST) begin
                            state_d = ST_FAULT;
                            cause_d = C_WDOG;
                        end
                    end else begin
                        wdt_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                cyc_d = cyc_q + DATA_WIDTH'(1);
                if (drain_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_d = drain_q - DCW'(1);
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_BOOT;
            cause_q  <= C_NONE;
            pc_q     <= RESET_PC;
            cyc_q    <= '0;
            wdt_q    <= '0;
            drain_q  <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            pc_q     <= pc_d;
            cyc_q    <= cyc_d;
            wdt_q    <= wdt_d;
            drain_q  <= drain_d;
            halted_q <= (state_d == ST_HALTED) || (state_d == ST_FAULT);
            fault_q  <= (state_d == ST_FAULT);
        end
    end

    assign pc_o        = pc_q;
    assign state_o     = state_q;
    assign cause_o     = cause_q;
    assign halted_o    = halted_q;
    assign fault_o     = fault_q;
    assign cycle_cnt_o = cyc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed bench for pc_sequencer with a queue-based scoreboard.
module tb_pc_sequencer;

    localparam int          DW   = 64;
    localparam logic [63:0] RPC  = 64'h0000_0000_8000_0000;
    localparam int          DRN  = 3;
    localparam int          WLIM = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          run_i;
    logic [3:0]    exceptions_i;
    logic [DW-1:0] new_pc_i;
    logic [DW-1:0] pc_o;
    logic [2:0]    state_o;
    logic          halted_o;
    logic          fault_o;
    logic [2:0]    cause_o;
    logic [DW-1:0] cycle_cnt_o;

    always #5 clk_i = ~clk_i;

    pc_sequencer #(
        .DATA_WIDTH  (DW),
        .RESET_PC    (RPC),
        .DRAIN_CYCLES(DRN),
        .WDT_WIDTH   (16),
        .WDT_LIMIT   (16'(WLIM))
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .new_pc_i    (new_pc_i),
        .exceptions_i(exceptions_i),
        .run_i       (run_i),
        .pc_o        (pc_o),
        .state_o     (state_o),
        .halted_o    (halted_o),
        .fault_o     (fault_o),
        .cause_o     (cause_o),
        .cycle_cnt_o (cycle_cnt_o)
    );

    typedef struct {
        logic [63:0] pc;
        int          state;
        int          cause;
        logic [63:0] cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model: architectural view (state codes, remaining drain cycles, unchanged-PC run length).
    logic [63:0] m_pc;
    logic [63:0] m_cyc;
    int          m_state;
    int          m_cause;
    int          m_same;
    int          m_drain_left;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", name, act, expv, $time);
        end
    endtask

    task automatic go_fault(input int c);
        m_state = 4;
        m_cause = c;
    endtask

    task automatic step(input logic rst, input logic run, input logic [3:0] exc, input logic [63:0] npc);
        exp_t e;
        rst_i        = rst;
        run_i        = run;
        exceptions_i = exc;
        new_pc_i     = npc;
        if (rst) begin
            m_pc = RPC; m_cyc = '0; m_state = 0; m_cause = 0; m_same = 0; m_drain_left = 0;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: begin
                    if (exc[0])      go_fault(1);
                    else if (exc[1]) go_fault(2);
                    else if (exc[2] || exc[3]) begin
                        m_state      = 2;
                        m_cause      = exc[2] ? 3 : 4;
                        m_drain_left = DRN;
                    end else if (run) begin
                        if (npc[1:0] != 2'b00) go_fault(6);
                        else begin
                            m_cyc = m_cyc + 1;
                            m_same = (npc == m_pc) ? m_same + 1 : 0;
                            m_pc = npc;
                            if (m_same == WLIM) go_fault(5);
                        end
                    end
                end
                2: begin
                    m_cyc = m_cyc + 1;
                    m_drain_left--;
                    if (m_drain_left == 0) m_state = 3;
                end
                default: ;
            endcase
        end
        e.pc = m_pc; e.state = m_state; e.cause = m_cause; e.cyc = m_cyc;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic adv(input int n);
        repeat (n) step(1'b0, 1'b1, 4'b0000, m_pc + 64'd4);
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(1'b1, 1'($urandom), 4'($urandom), {$urandom, $urandom});
    endtask

    // Monitor: every cycle presents an output; compare it against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("pc_o",        pc_o,                  mon_e.pc);
                chk("state_o",     64'(state_o),          64'(mon_e.state));
                chk("cause_o",     64'(cause_o),          64'(mon_e.cause));
                chk("cycle_cnt_o", cycle_cnt_o,           mon_e.cyc);
                chk("halted_o",    64'(halted_o),         (mon_e.state >= 3) ? 64'd1 : 64'd0);
                chk("fault_o",     64'(fault_o),          (mon_e.state == 4) ? 64'd1 : 64'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, got no end expected end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] npc;
        int          r;
        rst_i = 1'b1; run_i = 1'b0; exceptions_i = '0; new_pc_i = '0;

        // Boot, two advances, redirect, stalls below the watchdog limit, then clear.
        do_reset(2);
        adv(3);
        step(1'b0, 1'b1, 4'b0000, 64'h8000_0100);
        repeat (3) step(1'b0, 1'b1, 4'b0000, m_pc);
        adv(1);
        repeat (3) step(1'b0, 1'b1, 4'b0000, m_pc);
        adv(1);

        // ECALL at 0x8000_0010, drain, halt; later FetchError ignored.
        do_reset(1);
        adv(5);
        step(1'b0, 1'b1, 4'b0100, m_pc + 64'd4);
        repeat (6) step(1'b0, 1'b1, 4'b0001, m_pc + 64'd4);

        // Exception priority: FetchError over DecodeError and EBREAK.
        do_reset(1);
        adv(2);
        step(1'b0, 1'b1, 4'b1011, m_pc + 64'd4);
        adv(2);

        // Pause then misaligned target.
        do_reset(1);
        adv(3);
        repeat (5) step(1'b0, 1'b0, 4'b0000, m_pc + 64'd4);
        step(1'b0, 1'b1, 4'b0000, 64'h8000_0002);
        adv(2);

        // Watchdog: fourth unchanged cycle faults.
        do_reset(1);
        adv(2);
        repeat (5) step(1'b0, 1'b1, 4'b0000, m_pc);

        // EBREAK while paused, then reset mid-drain.
        do_reset(1);
        adv(2);
        step(1'b0, 1'b0, 4'b1000, m_pc + 64'd4);
        adv(1);
        do_reset(1);
        adv(3);

        // Randomised run.
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            if ((m_state >= 3 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
                do_reset(1);
            end else begin
                r = int'($urandom_range(0, 15));
                if (r < 8)       npc = m_pc + 64'd4;
                else if (r < 12) npc = m_pc;
                else if (r < 14) npc = {$urandom, $urandom} & ~64'h3;
                else if (r < 15) npc = m_pc + 64'($urandom_range(1, 3));
                else             npc = m_pc - 64'd8;
                step(1'b0, ($urandom_range(0, 7) != 0),
                     ($urandom_range(0, 29) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000, npc);
            end
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk_i);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
